// File: rtl/fde_sequencer.sv
// Fetch/decode/execute sequencer: owns pc and ir, fetches over a req/ack port,
// and emits one-hot phase strobes that qualify the downstream decoder.
module fde_sequencer #(
  parameter int ADDR_W = 8,
  parameter int IR_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IR_W-1:0]   ir,
  output logic              fetch,
  output logic              decode,
  output logic              execute,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              halt_req,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          instr_cnt <= instr_cnt + CNT_W'(1);
          // A taken jump replaces the increment already applied during fetch.
          if (pc_load) pc <= pc_load_val;
          state <= halt_req ? S_HALT : S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign fetch    = (state == S_FETCH);
  assign decode   = (state == S_DECODE);
  assign execute  = (state == S_EXECUTE);
  assign halted   = (state == S_HALT);
  // Request is suppressed while reset is held so memory never sees a stray read.
  assign mem_rd   = fetch & ~rst;
  assign mem_addr = pc;

endmodule

// File: tb/tb_fde_sequencer.sv
// Directed bench for fde_sequencer: a small pc/ir/count model plus a queue of
// fetched instructions that is checked when each one reaches DECODE.
module tb_fde_sequencer;
  localparam int ADDR_W = 8;
  localparam int IR_W   = 8;
  // Narrow counter keeps the wrap test short; the counter logic is width-generic.
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [IR_W-1:0]   mem_rdata;
  logic              mem_ack;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [IR_W-1:0]   ir;
  logic              fetch, decode, execute, halted;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              halt_req;
  logic [CNT_W-1:0]  instr_cnt;

  fde_sequencer #(.ADDR_W(ADDR_W), .IR_W(IR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .ir(ir), .fetch(fetch),
    .decode(decode), .execute(execute), .pc(pc), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .halt_req(halt_req), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [IR_W-1:0]   ir;
  } exp_t;

  exp_t q[$];
  logic [ADDR_W-1:0] m_pc;
  logic [IR_W-1:0]   m_ir;
  logic [CNT_W-1:0]  m_cnt;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_fetch(input string tag);
    chk({tag, ".fetch"}, {31'd0, fetch}, 32'd1);
    chk({tag, ".mem_rd"}, {31'd0, mem_rd}, 32'd1);
    chk({tag, ".addr"}, {24'd0, mem_addr}, {24'd0, m_pc});
    chk({tag, ".pc"}, {24'd0, pc}, {24'd0, m_pc});
    chk({tag, ".ir"}, {24'd0, ir}, {24'd0, m_ir});
    chk({tag, ".cnt"}, {22'd0, instr_cnt}, {22'd0, m_cnt});
  endtask

  // One full instruction starting at a FETCH negedge. noise drives every
  // input that DECODE must ignore.
  task automatic run_instr(input logic [IR_W-1:0] data, input int waits,
                           input logic noise, input logic load,
                           input logic [ADDR_W-1:0] load_val, input logic halt);
    exp_t e;
    chk_idle_fetch("fetch");
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait.mem_rd", {31'd0, mem_rd}, 32'd1);
      chk("wait.addr", {24'd0, mem_addr}, {24'd0, m_pc});
      chk("wait.ir", {24'd0, ir}, {24'd0, m_ir});
    end
    mem_ack = 1'b1; mem_rdata = data;
    q.push_back('{addr: m_pc, ir: data});
    m_pc = m_pc + 8'd1; m_ir = data;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    e = q.pop_front();
    chk("dec.decode", {31'd0, decode}, 32'd1);
    chk("dec.mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("dec.ir", {24'd0, ir}, {24'd0, e.ir});
    chk("dec.pc", {24'd0, pc}, {24'd0, e.addr + 8'd1});
    if (noise) begin
      mem_ack = 1'b1; mem_rdata = 8'hAA;
      pc_load = 1'b1; pc_load_val = 8'h77; halt_req = 1'b1;
    end
    tick();
    mem_ack = 1'b0; pc_load = 1'b0; halt_req = 1'b0;
    chk("exe.execute", {31'd0, execute}, 32'd1);
    chk("exe.ir", {24'd0, ir}, {24'd0, m_ir});
    chk("exe.pc", {24'd0, pc}, {24'd0, m_pc});
    pc_load = load; pc_load_val = load_val; halt_req = halt;
    tick();
    pc_load = 1'b0; halt_req = 1'b0;
    m_cnt = m_cnt + 1'b1;
    if (load) m_pc = load_val;
    if (halt) begin
      chk("halt.halted", {31'd0, halted}, 32'd1);
      chk("halt.mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("halt.pc", {24'd0, pc}, {24'd0, m_pc});
      chk("halt.cnt", {22'd0, instr_cnt}, {22'd0, m_cnt});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst.mem_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    chk("rst.mem_rd2", {31'd0, mem_rd}, 32'd0);
    rst = 1'b0;
    m_pc = '0; m_ir = '0; m_cnt = '0;
    q.delete();
    #1;
    chk_idle_fetch("post_rst");
  endtask

  initial begin
    rst = 1'b1; mem_rdata = '0; mem_ack = 1'b0;
    pc_load = 1'b0; pc_load_val = '0; halt_req = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-wait fetch of 0xE0 at address 0.
    run_instr(8'hE0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_idle_fetch("t1");

    // Wait states in FETCH, noise in DECODE.
    run_instr(8'h5A, 3, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_idle_fetch("t2");

    // Jump to 0x10, then a jump from 0x10 to 0x42.
    run_instr(8'h11, 0, 1'b0, 1'b1, 8'h10, 1'b0);
    chk("t3.addr10", {24'd0, mem_addr}, 32'h10);
    run_instr(8'h22, 1, 1'b0, 1'b1, 8'h42, 1'b0);
    chk("t3.addr42", {24'd0, mem_addr}, 32'h42);
    // Jump back to 0x10 with decode-time noise only: next fetch from 0x11.
    run_instr(8'h33, 0, 1'b0, 1'b1, 8'h10, 1'b0);
    run_instr(8'h44, 0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t3.addr11", {24'd0, mem_addr}, 32'h11);

    // pc wrap from 0xFF.
    run_instr(8'h55, 0, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_instr(8'h66, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4.pcwrap", {24'd0, pc}, 32'h00);

    // Counter wrap: run up to all-ones, then one more.
    while (m_cnt != {CNT_W{1'b1}})
      run_instr(m_cnt[7:0], 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4.cntmax", {22'd0, instr_cnt}, 32'h3FF);
    run_instr(8'h77, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4.cntwrap", {22'd0, instr_cnt}, 32'h000);

    // Jump and halt together, then poke inputs while halted.
    run_instr(8'h88, 2, 1'b0, 1'b1, 8'h30, 1'b1);
    for (int i = 0; i < 10; i++) begin
      mem_ack = i[0]; mem_rdata = 8'hC3; pc_load = ~i[0]; pc_load_val = 8'h99;
      halt_req = i[1];
      tick();
      chk("hlt.halted", {31'd0, halted}, 32'd1);
      chk("hlt.mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("hlt.pc", {24'd0, pc}, {24'd0, m_pc});
      chk("hlt.ir", {24'd0, ir}, {24'd0, m_ir});
      chk("hlt.cnt", {22'd0, instr_cnt}, {22'd0, m_cnt});
    end
    mem_ack = 1'b0; pc_load = 1'b0; halt_req = 1'b0;
    do_reset();

    // Reset on the same edge as a fetch ack.
    run_instr(8'h12, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    mem_ack = 1'b1; mem_rdata = 8'h9C; rst = 1'b1;
    tick();
    mem_ack = 1'b0; rst = 1'b0;
    m_pc = '0; m_ir = '0; m_cnt = '0;
    #1;
    chk_idle_fetch("t6");
    run_instr(8'hE1, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_idle_fetch("t6.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
